// File: rtl/gray_bin_pkg.sv
// Shared types and constants for the round-robin Gray-to-binary controller.
package gray_bin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; on a tie the requester that did not win last time is chosen.
module rr_arb2
    import gray_bin_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = REQ0;
        if (valid0 && valid1) begin
            grant_id = ~last_grant;
        end else if (valid1) begin
            grant_id = REQ1;
        end
    end

endmodule

// File: rtl/gray_bin_rr_ctrl.sv
// Two-requester controller sharing one bit-serial Gray-to-binary stage, MSB first, one bit per clock.
module gray_bin_rr_ctrl
    import gray_bin_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_gray,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_gray,
    output logic         req1_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_bin,
    output logic         out_id
);

    localparam int CW = $clog2(W);

    state_t         state;
    state_t         next_state;
    logic [W-1:0]   gray_reg;
    logic [W-1:0]   bin_reg;
    logic [CW-1:0]  cnt;
    logic           id_reg;
    logic           last_grant;
    logic           grant_valid;
    logic           grant_id;
    logic           accept;
    logic           prev_bit;
    logic           conv_bit;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CONV;
            CONV:    if (cnt == '0) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == IDLE) && grant_valid && (grant_id == REQ0) && req0_valid && !rst;
        req1_ready = (state == IDLE) && grant_valid && (grant_id == REQ1) && req1_valid && !rst;
        out_valid  = (state == DONE);
    end

    assign accept = req0_ready | req1_ready;

    // The MSB has no higher binary bit, so its XOR partner is zero.
    always_comb begin
        prev_bit = 1'b0;
        if (cnt != CW'(W - 1)) begin
            prev_bit = bin_reg[cnt + 1'b1];
        end
    end

    assign conv_bit = gray_reg[cnt] ^ prev_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_reg   <= '0;
            bin_reg    <= '0;
            cnt        <= '0;
            id_reg     <= REQ0;
            last_grant <= REQ1;
            out_bin    <= '0;
            out_id     <= REQ0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gray_reg   <= (grant_id == REQ1) ? req1_gray : req0_gray;
                        id_reg     <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= CW'(W - 1);
                    end
                end
                CONV: begin
                    bin_reg[cnt] <= conv_bit;
                    cnt          <= cnt - 1'b1;
                    // Publish the finished word together with the last bit.
                    if (cnt == '0) begin
                        out_bin <= {bin_reg[W-1:1], conv_bit};
                        out_id  <= id_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_bin_rr_ctrl.sv
// Directed self-checking bench for gray_bin_rr_ctrl at W=4 and W=8.
module tb_gray_bin_rr_ctrl;

    logic       clk;
    logic       rst;
    logic       r0v, r1v, r0r, r1r, ov, ordy, oid;
    logic [3:0] r0g, r1g, ob;
    logic       p0v, p1v, p0r, p1r, ov8, ordy8, oid8;
    logic [7:0] p0g, p1g, ob8;

    int n_checks = 0;
    int n_fail   = 0;

    gray_bin_rr_ctrl #(.W(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_gray(r0g), .req0_ready(r0r),
        .req1_valid(r1v), .req1_gray(r1g), .req1_ready(r1r),
        .out_valid(ov), .out_ready(ordy), .out_bin(ob), .out_id(oid)
    );

    gray_bin_rr_ctrl #(.W(8)) dut8 (
        .clk(clk), .rst(rst),
        .req0_valid(p0v), .req0_gray(p0g), .req0_ready(p0r),
        .req1_valid(p1v), .req1_gray(p1g), .req1_ready(p1r),
        .out_valid(ov8), .out_ready(ordy8), .out_bin(ob8), .out_id(oid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a word on the W=4 instance and holds it until accepted.
    task automatic send4(input bit id, input logic [3:0] g, output bit accepted);
        accepted = 1'b0;
        if (id) begin r1v = 1'b1; r1g = g; end
        else    begin r0v = 1'b1; r0g = g; end
        for (int i = 0; i < 40; i++) begin
            #1;
            if ((id ? r1r : r0r) === 1'b1) begin
                @(posedge clk);
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1;
        if (id) r1v = 1'b0; else r0v = 1'b0;
    endtask

    task automatic send8(input logic [7:0] g, output bit accepted);
        accepted = 1'b0;
        p0v = 1'b1; p0g = g;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (p0r === 1'b1) begin
                @(posedge clk);
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1;
        p0v = 1'b0;
    endtask

    task automatic wait_valid4(output int edges);
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ov === 1'b1) begin edges = i; break; end
        end
    endtask

    task automatic wait_valid8(output int edges);
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ov8 === 1'b1) begin edges = i; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ordy = 1'b1; ordy8 = 1'b1;
        r0v = 1'b1; r1v = 1'b1; r0g = 4'b0101; r1g = 4'b1010;
        p0v = 1'b0; p1v = 1'b0; p0g = '0; p1g = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (r0r !== 1'b0 || r1r !== 1'b0) begin
                n_fail++; $display("[TB] FAIL reset_ready: got %b%b required 00", r0r, r1r);
            end
            n_checks++;
            if (ov !== 1'b0) begin
                n_fail++; $display("[TB] FAIL reset_out_valid: got %b required 0", ov);
            end
            n_checks++;
            if (ob !== 4'b0000 || oid !== 1'b0) begin
                n_fail++; $display("[TB] FAIL reset_out: got bin=%b id=%b required 0000/0", ob, oid);
            end
        end
        rst = 1'b0; #1;
        n_checks++;
        if (r0r !== 1'b1 || r1r !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_first_grant: got %b%b required r0=1 r1=0", r0r, r1r);
        end
        r0v = 1'b0; r1v = 1'b0;
    endtask

    task automatic test_tie;
        int edges;
        logic [3:0] exp_bin [4] = '{4'b0100, 4'b1111, 4'b0100, 4'b1111};
        rst = 1'b1; ordy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int round = 0; round < 2; round++) begin
            r0v = 1'b1; r0g = 4'b0110; r1v = 1'b1; r1g = 4'b1000;
            for (int k = 0; k < 2; k++) begin
                #1;
                n_checks++;
                if ((k == 0 && (r0r !== 1'b1 || r1r !== 1'b0)) ||
                    (k == 1 && (r1r !== 1'b1 || r0r !== 1'b0))) begin
                    n_fail++; $display("[TB] FAIL tie_grant%0d: got r0=%b r1=%b required grant %0d", round*2+k, r0r, r1r, k);
                end
                @(posedge clk); #1;
                if (k == 0) r0v = 1'b0; else r1v = 1'b0;
                wait_valid4(edges);
                n_checks++;
                if (edges != 4 || ob !== exp_bin[round*2+k] || oid !== 1'(k)) begin
                    n_fail++; $display("[TB] FAIL tie_result%0d: got edges=%0d bin=%b id=%b required 4/%b/%0d", round*2+k, edges, ob, oid, exp_bin[round*2+k], k);
                end
                @(posedge clk);
            end
        end
        #1;
    endtask

    task automatic test_single_request;
        bit acc;
        int edges;
        r0v = 1'b1; r0g = 4'b1011; #1;
        n_checks++;
        if (r0r !== 1'b1 || r1r !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_ready: got r0=%b r1=%b required 1/0", r0r, r1r);
        end
        @(posedge clk); #1;
        r0v = 1'b0;
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (r1r !== 1'b0) begin
                n_fail++; $display("[TB] FAIL single_r1_ready: got %b required 0 at edge %0d", r1r, i);
            end
            if (ov === 1'b1) begin edges = i; break; end
        end
        n_checks++;
        if (edges != 4) begin
            n_fail++; $display("[TB] FAIL single_latency: got %0d required 4", edges);
        end
        n_checks++;
        if (ob !== 4'b1101 || oid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_result: got %b/%b required 1101/0", ob, oid);
        end
        @(posedge clk); #1;
        acc = 1'b0;
    endtask

    task automatic test_backpressure;
        bit acc;
        int edges;
        ordy = 1'b0;
        send4(1'b0, 4'b0011, acc);
        n_checks++;
        if (!acc) begin
            n_fail++; $display("[TB] FAIL bp_accept: got timeout required accept");
        end
        r1v = 1'b1; r1g = 4'b0110;
        wait_valid4(edges);
        n_checks++;
        if (edges != 4 || ob !== 4'b0010 || oid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL bp_result: got edges=%0d %b/%b required 4/0010/0", edges, ob, oid);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ov !== 1'b1 || ob !== 4'b0010 || oid !== 1'b0 || r0r !== 1'b0 || r1r !== 1'b0) begin
                n_fail++; $display("[TB] FAIL bp_hold%0d: got v=%b bin=%b id=%b rdy=%b%b required 1/0010/0/00", c, ov, ob, oid, r0r, r1r);
            end
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ov !== 1'b0 || r1r !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bp_release: got v=%b r1_ready=%b required 0/1", ov, r1r);
        end
        @(posedge clk); #1;
        r1v = 1'b0;
        wait_valid4(edges);
        n_checks++;
        if (edges != 4 || ob !== 4'b0100 || oid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bp_pending: got edges=%0d %b/%b required 4/0100/1", edges, ob, oid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_conv;
        bit acc;
        int edges;
        send4(1'b1, 4'b1111, acc);
        @(posedge clk); #1;
        rst = 1'b1;
        r0v = 1'b1; r0g = 4'b0110; r1v = 1'b1; r1g = 4'b1000;
        #1;
        n_checks++;
        if (r0r !== 1'b0 || r1r !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midrst_ready: got %b%b required 00", r0r, r1r);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ov !== 1'b0 || ob !== 4'b0000 || oid !== 1'b0 || r0r !== 1'b0 || r1r !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midrst_state: got v=%b bin=%b id=%b rdy=%b%b required 0/0000/0/00", ov, ob, oid, r0r, r1r);
        end
        rst = 1'b0; #1;
        n_checks++;
        if (r0r !== 1'b1 || r1r !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midrst_tie: got r0=%b r1=%b required 1/0", r0r, r1r);
        end
        @(posedge clk); #1;
        r0v = 1'b0;
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ov === 1'b1) begin edges = i; break; end
        end
        n_checks++;
        if (edges != 4 || ob !== 4'b0100 || oid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midrst_result: got edges=%0d %b/%b required 4/0100/0", edges, ob, oid);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        r1v = 1'b0;
        wait_valid4(edges);
        n_checks++;
        if (edges != 4 || ob !== 4'b1111 || oid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midrst_r1: got edges=%0d %b/%b required 4/1111/1", edges, ob, oid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_boundaries;
        bit acc;
        int edges;
        logic [3:0] g4 [3] = '{4'b0000, 4'b1111, 4'b1000};
        logic [3:0] b4 [3] = '{4'b0000, 4'b1010, 4'b1111};
        logic [7:0] g8 [2] = '{8'b10000000, 8'b00000001};
        logic [7:0] b8 [2] = '{8'b11111111, 8'b00000001};
        for (int i = 0; i < 3; i++) begin
            send4(1'b0, g4[i], acc);
            wait_valid4(edges);
            n_checks++;
            if (!acc || edges != 4 || ob !== b4[i] || oid !== 1'b0) begin
                n_fail++; $display("[TB] FAIL w4_boundary%0d: got acc=%b edges=%0d bin=%b required 1/4/%b", i, acc, edges, ob, b4[i]);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            send8(g8[i], acc);
            wait_valid8(edges);
            n_checks++;
            if (!acc || edges != 8 || ob8 !== b8[i] || oid8 !== 1'b0) begin
                n_fail++; $display("[TB] FAIL w8_boundary%0d: got acc=%b edges=%0d bin=%b required 1/8/%b", i, acc, edges, ob8, b8[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_request();
        test_backpressure();
        test_reset_mid_conv();
        test_boundaries();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
